// File: rtl/memory_stage.sv
// MEM stage: data-memory access over req/gnt/rvalid, store lane
// alignment, load extension, hazard stall and the MEM/WB register.
module memory_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_alu_result_m,
  input  logic [DATA_WIDTH-1:0] i_write_data_m,
  input  logic                  i_regwrite_m,
  input  logic                  i_memwrite_m,
  input  logic [1:0]            i_resultsrc_m,
  input  logic [1:0]            i_storetype_m,
  input  logic [2:0]            i_loadtype_m,
  input  logic [4:0]            i_rd_addr_m,
  input  logic [ADDR_WIDTH-1:0] i_pc4_m,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [ADDR_WIDTH-1:0] o_dmem_addr,
  output logic [31:0]           o_dmem_wdata,
  output logic [3:0]            o_dmem_be,
  input  logic                  i_dmem_gnt,
  input  logic                  i_dmem_rvalid,
  input  logic [31:0]           i_dmem_rdata,
  output logic [DATA_WIDTH-1:0] o_forward_m,
  output logic                  o_stall_m,
  output logic                  o_misaligned_m,
  output logic                  o_regwrite_w,
  output logic [1:0]            o_resultsrc_w,
  output logic [4:0]            o_rd_addr_w,
  output logic [DATA_WIDTH-1:0] o_alu_result_w,
  output logic [31:0]           o_read_data_w,
  output logic [ADDR_WIDTH-1:0] o_pc4_w
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID
  } state_t;

  state_t state, state_n;

  logic        is_store;
  logic        is_load;
  logic        mem_op;
  logic        mis;
  logic        aligned;
  logic        complete;
  logic [1:0]  off;
  logic [31:0] rshift;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_val;

  assign off      = i_alu_result_m[1:0];
  assign is_store = i_memwrite_m;
  assign is_load  = ~i_memwrite_m & (i_resultsrc_m == 2'b01);
  assign mem_op   = is_store | is_load;
  assign aligned  = mem_op & ~mis;

  always_comb begin
    mis = 1'b0;
    if (is_store) begin
      unique case (i_storetype_m)
        2'b00: mis = 1'b0;
        2'b01: mis = off[0];
        2'b10: mis = |off;
        2'b11: mis = 1'b1;
      endcase
    end else if (is_load) begin
      case (i_loadtype_m)
        3'b001,
        3'b101:  mis = off[0];
        3'b010:  mis = |off;
        default: mis = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_n;
  end

  // Request is held through WAIT_GNT; inputs are frozen by the stall.
  always_comb begin
    state_n    = state;
    o_dmem_req = 1'b0;
    complete   = 1'b0;
    unique case (state)
      IDLE, WAIT_GNT: begin
        if (aligned) begin
          o_dmem_req = 1'b1;
          if (i_dmem_gnt) begin
            complete = is_store;
            state_n  = is_store ? IDLE : WAIT_RVALID;
          end else begin
            state_n  = WAIT_GNT;
          end
        end else begin
          state_n = IDLE;
        end
      end
      WAIT_RVALID: begin
        if (i_dmem_rvalid) begin
          complete = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign o_stall_m   = aligned & ~complete;
  assign o_dmem_we   = o_dmem_req & is_store;
  assign o_dmem_addr = {i_alu_result_m[ADDR_WIDTH-1:2], 2'b00};
  assign o_forward_m = i_alu_result_m;

  always_comb begin
    o_dmem_be    = 4'b1111;
    o_dmem_wdata = i_write_data_m[31:0];
    if (is_store) begin
      unique case (i_storetype_m)
        2'b00: begin
          o_dmem_be    = 4'b0001 << off;
          o_dmem_wdata = {4{i_write_data_m[7:0]}};
        end
        2'b01: begin
          o_dmem_be    = 4'b0011 << {off[1], 1'b0};
          o_dmem_wdata = {2{i_write_data_m[15:0]}};
        end
        2'b10, 2'b11: begin
          o_dmem_be    = 4'b1111;
          o_dmem_wdata = i_write_data_m[31:0];
        end
      endcase
    end
  end

  assign rshift = i_dmem_rdata >> {off, 3'b000};
  assign rbyte  = rshift[7:0];
  assign rhalf  = off[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];

  always_comb begin
    case (i_loadtype_m)
      3'b000:  load_val = {{24{rbyte[7]}}, rbyte};
      3'b001:  load_val = {{16{rhalf[15]}}, rhalf};
      3'b100:  load_val = {24'b0, rbyte};
      3'b101:  load_val = {16'b0, rhalf};
      default: load_val = i_dmem_rdata;
    endcase
  end

  // Stall and misaligned cycles retire as bubbles (regwrite cleared).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_regwrite_w   <= 1'b0;
      o_resultsrc_w  <= 2'b00;
      o_rd_addr_w    <= 5'd0;
      o_alu_result_w <= '0;
      o_read_data_w  <= 32'd0;
      o_pc4_w        <= '0;
      o_misaligned_m <= 1'b0;
    end else begin
      o_regwrite_w   <= i_regwrite_m & (~mem_op | complete);
      o_resultsrc_w  <= i_resultsrc_m;
      o_rd_addr_w    <= i_rd_addr_m;
      o_alu_result_w <= i_alu_result_m;
      o_read_data_w  <= load_val;
      o_pc4_w        <= i_pc4_m;
      o_misaligned_m <= mem_op & mis & (state == IDLE);
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Randomized scoreboard bench for memory_stage with a byte-level
// data-memory model and per-cycle bus/stall checks.
module tb_memory_stage;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   alu, wd;
  logic          rw, mw;
  logic [1:0]    rs, st;
  logic [2:0]    lt;
  logic [4:0]    rd;
  logic [AW-1:0] pc4;
  logic          req, we, gnt, rvalid;
  logic [AW-1:0] daddr;
  logic [31:0]   wdata, rdata;
  logic [3:0]    be;
  logic [31:0]   fwd;
  logic          stall, misal;
  logic          rw_w;
  logic [1:0]    rs_w;
  logic [4:0]    rd_w;
  logic [31:0]   alu_w, rdat_w;
  logic [AW-1:0] pc4_w;

  always #5 clk = ~clk;

  memory_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_alu_result_m(alu), .i_write_data_m(wd),
    .i_regwrite_m(rw), .i_memwrite_m(mw),
    .i_resultsrc_m(rs), .i_storetype_m(st),
    .i_loadtype_m(lt), .i_rd_addr_m(rd), .i_pc4_m(pc4),
    .o_dmem_req(req), .o_dmem_we(we), .o_dmem_addr(daddr),
    .o_dmem_wdata(wdata), .o_dmem_be(be),
    .i_dmem_gnt(gnt), .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata),
    .o_forward_m(fwd), .o_stall_m(stall), .o_misaligned_m(misal),
    .o_regwrite_w(rw_w), .o_resultsrc_w(rs_w), .o_rd_addr_w(rd_w),
    .o_alu_result_w(alu_w), .o_read_data_w(rdat_w), .o_pc4_w(pc4_w)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [1:0]  rs;
    logic [31:0] val;
  } wb_t;

  wb_t         q[$];
  logic [31:0] mem[256];
  int          nvec = 0;
  int          nerr = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] load_model(logic [31:0] word,
                                             logic [2:0] t, int o);
    int b, h;
    b = int'((word >> (8 * o)) & 32'hFF);
    h = int'((word >> (16 * (o / 2))) & 32'hFFFF);
    case (t)
      3'b000:  return (b >= 128) ? 32'(b - 256) : 32'(b);
      3'b001:  return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      3'b100:  return 32'(b);
      3'b101:  return 32'(h);
      default: return word;
    endcase
  endfunction

  function automatic bit mis_model(bit s, bit l, logic [1:0] stt,
                                   logic [2:0] t, int o);
    if (s) return stt == 3 || (stt == 1 && o % 2 == 1) || (stt == 2 && o != 0);
    if (l) return ((t == 1 || t == 5) && o % 2 == 1) || (t == 2 && o != 0);
    return 0;
  endfunction

  // Writeback monitor: every architectural write must match the oldest entry.
  initial begin
    wb_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && rw_w) begin
        if (q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL wb_unexpected: rd %0d written, expected no write", rd_w);
        end else begin
          e = q.pop_front();
          chk("wb_rd", 32'(rd_w), 32'(e.rd));
          chk("wb_rs", 32'(rs_w), 32'(e.rs));
          case (e.rs)
            2'b00:   chk("wb_alu", alu_w, e.val);
            2'b01:   chk("wb_load", rdat_w, e.val);
            default: chk("wb_pc4", 32'(pc4_w), e.val);
          endcase
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] d,
                       input logic w, input logic [1:0] r,
                       input logic [1:0] s, input logic [2:0] l,
                       input logic [4:0] dst, input logic wr,
                       input int dg, input int dr);
    int          o, wi;
    bit          sto, ldo, memop, m;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    wb_t         e;
    o     = int'(a[1:0]);
    wi    = int'(a[9:2]);
    sto   = w;
    ldo   = !w && r == 2'b01;
    memop = sto || ldo;
    m     = mis_model(sto, ldo, s, l, o);
    @(negedge clk);
    alu = a; wd = d; mw = w; rs = r; st = s; lt = l; rd = dst; rw = wr;
    pc4 = AW'($urandom);
    gnt = 1'b0; rvalid = 1'b0;
    if (wr && !(memop && m)) begin
      e.rd = dst;
      e.rs = r;
      e.val = ldo ? load_model(mem[wi], l, o) :
              (r == 2'b10) ? 32'(pc4) : a;
      q.push_back(e);
    end
    if (!memop || m) begin
      #1;
      chk("req_none", 32'(req), 0);
      chk("stall_none", 32'(stall), 0);
      @(posedge clk);
      #1;
      chk("misaligned_flag", 32'(misal), 32'(m));
      return;
    end
    for (int i = 0; i < dg; i++) begin
      #1;
      chk("req_wait", 32'(req), 1);
      chk("stall_wait", 32'(stall), 1);
      @(negedge clk);
    end
    case (s)
      2'b00:   begin ebe = 4'b0001 << o; ewd = {4{d[7:0]}}; end
      2'b01:   begin ebe = 4'b0011 << o; ewd = {2{d[15:0]}}; end
      default: begin ebe = 4'b1111; ewd = d; end
    endcase
    if (ldo) ebe = 4'b1111;
    gnt = 1'b1;
    #1;
    chk("req_gnt", 32'(req), 1);
    chk("we", 32'(we), 32'(sto));
    chk("addr", 32'(daddr), {22'd0, a[9:2], 2'b00});
    chk("be", 32'(be), 32'(ebe));
    chk("stall_gnt", 32'(stall), 32'(ldo));
    if (sto) begin
      chk("wdata", wdata, ewd);
      for (int k = 0; k < 4; k++)
        if (ebe[k]) mem[wi][8*k +: 8] = ewd[8*k +: 8];
      return;
    end
    @(negedge clk);
    gnt = 1'b0;
    for (int i = 0; i < dr - 1; i++) begin
      #1;
      chk("req_rvwait", 32'(req), 0);
      chk("stall_rvwait", 32'(stall), 1);
      @(negedge clk);
    end
    rvalid = 1'b1;
    rdata = mem[wi];
    #1;
    chk("stall_rvalid", 32'(stall), 0);
  endtask

  initial begin
    logic [2:0] ltab[5];
    ltab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    rst_n = 1'b0;
    alu = 0; wd = 0; mw = 0; rs = 0; st = 0; lt = 0; rd = 0; rw = 0;
    pc4 = 0; gnt = 0; rvalid = 0; rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_regwrite", 32'(rw_w), 0);
    chk("rst_alu_w", alu_w, 0);
    chk("rst_req", 32'(req), 0);
    chk("rst_stall", 32'(stall), 0);
    rst_n = 1'b1;

    issue(32'h1234, 0, 0, 2'b00, 0, 0, 5'd5, 1, 0, 0);
    issue(32'h6, 32'hAABBCCDD, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    mem[0] = 32'h8012_3456;
    issue(32'h3, 0, 0, 2'b01, 0, 3'b000, 5'd7, 1, 2, 2);
    mem[0] = 32'h9ABC_1234;
    issue(32'h2, 0, 0, 2'b01, 0, 3'b101, 5'd8, 1, 0, 1);
    issue(32'h4, 0, 0, 2'b01, 0, 3'b010, 5'd9, 1, 1, 1);
    issue(32'h5, 32'h1111_2222, 1, 2'b00, 2'b10, 0, 0, 0, 0, 0);
    issue(32'h40, 0, 0, 2'b10, 0, 0, 5'd3, 1, 0, 0);

    for (int n = 0; n < 300; n++) begin
      int k = int'($urandom_range(0, 3));
      logic [31:0] a = $urandom;
      logic [4:0]  dst = 5'($urandom_range(1, 31));
      int dg = int'($urandom_range(0, 2));
      int dr = int'($urandom_range(1, 3));
      case (k)
        0: issue(a, 0, 0, ($urandom % 2) ? 2'b10 : 2'b00, 0, 0, dst, 1, 0, 0);
        1: issue(a, $urandom, 1, 2'b00, 2'($urandom), 0, 0, 0, dg, 0);
        default: issue(a, 0, 0, 2'b01, 0, ltab[$urandom_range(0, 4)],
                       dst, 1, dg, dr);
      endcase
    end

    @(negedge clk);
    alu = 32'h10; mw = 0; rs = 2'b01; lt = 3'b010; rd = 5'd4; rw = 1;
    gnt = 1'b1; rvalid = 1'b0;
    @(negedge clk);
    gnt = 1'b0;
    #1;
    chk("stall_before_rst", 32'(stall), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_regwrite", 32'(rw_w), 0);
    chk("rst_mid_alu_w", alu_w, 0);
    chk("rst_mid_rd_w", 32'(rd_w), 0);
    chk("rst_mid_misal", 32'(misal), 0);
    rs = 2'b00; rw = 0; alu = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rvalid = 1'b1;
    rdata = 32'hDEAD_BEEF;
    #1;
    chk("late_rvalid_stall", 32'(stall), 0);
    chk("late_rvalid_req", 32'(req), 0);
    @(negedge clk);
    rvalid = 1'b0;
    chk("late_rvalid_wb", 32'(rw_w), 0);
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
Memory (MEM) stage of the 5-stage RISC-V pipeline. It sits directly downstream of the execute stage and consumes its EX/MEM register outputs. It runs load/store accesses on a request/grant/response data-memory bus, aligns store data and byte enables, and sign- or zero-extends load data. It drives a stall to the hazard unit while an access is outstanding and owns the MEM/WB pipeline register.

Parameters:
DATA_WIDTH, 32, data path width (fixed at 32 for RV32I lane logic)
ADDR_WIDTH, 10, data-memory byte-address width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_alu_result_m  in  DATA_WIDTH  effective address or ALU result from EX/MEM
i_write_data_m  in  DATA_WIDTH  store data (forwarded rs2)
i_regwrite_m  in  1  register write enable
i_memwrite_m  in  1  store instruction
i_resultsrc_m  in  2  result select: 00 ALU, 01 load, 10 PC+4
i_storetype_m  in  2  00 SB, 01 SH, 10 SW, 11 reserved
i_loadtype_m  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
i_rd_addr_m  in  5  destination register
i_pc4_m  in  ADDR_WIDTH  PC+4
o_dmem_req  out  1  bus request
o_dmem_we  out  1  write request
o_dmem_addr  out  ADDR_WIDTH  word-aligned byte address, {alu[ADDR_WIDTH-1:2],2'b00}
o_dmem_wdata  out  32  lane-aligned store data
o_dmem_be  out  4  byte enables
i_dmem_gnt  in  1  request accepted
i_dmem_rvalid  in  1  read data valid
i_dmem_rdata  in  32  read word
o_forward_m  out  DATA_WIDTH  i_alu_result_m (combinational), for EX forwarding
o_stall_m  out  1  freeze IF/ID/EX/MEM-input registers
o_misaligned_m  out  1  one-cycle misaligned or reserved-access flag
o_regwrite_w, o_resultsrc_w(2), o_rd_addr_w(5), o_alu_result_w(DATA_WIDTH), o_read_data_w(32), o_pc4_w(ADDR_WIDTH)  out  MEM/WB register

Behaviour:
- mem_op = i_memwrite_m | (i_resultsrc_m==01). Non-mem ops pass to MEM/WB in 1 cycle with no stall.
- Misalignment: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; storetype 11.
  - On a misaligned or reserved access: no request is issued, o_misaligned_m pulses for 1 cycle, and the instruction retires as a bubble (o_regwrite_w=0).
- FSM states: IDLE, WAIT_GNT, WAIT_RVALID.
  - IDLE, aligned mem_op: o_dmem_req=1 combinationally.
    - gnt=1 on a store: the store completes this cycle.
    - gnt=1 on a load: go to WAIT_RVALID.
    - gnt=0: go to WAIT_GNT.
  - WAIT_GNT: req held with addr/we/wdata/be stable. On gnt, a store returns to IDLE (complete) and a load goes to WAIT_RVALID.
  - WAIT_RVALID: req=0. On rvalid the load completes and the FSM returns to IDLE.
  - rvalid in the same cycle as gnt (zero-latency memory) is not supported. rvalid in IDLE/WAIT_GNT is ignored.
- o_stall_m = aligned mem_op & ~complete_this_cycle.
  - Stores stall 0 cycles with immediate gnt. Loads stall at least 1 cycle.
  - While stalled, inputs are guaranteed stable by the hazard unit.
- MEM/WB register captures on completion or for non-mem ops. During stall cycles it loads a bubble: regwrite_w=0, other fields don't-care but registered.
- Store alignment:
  - SB: be=0001<<addr[1:0], wdata={4{wd[7:0]}}.
  - SH: be=0011<<{addr[1],1'b0}, wdata={2{wd[15:0]}}.
  - SW: be=1111, wdata=wd.
  - Loads drive be=1111 and we=0.
- Load extraction: select byte addr[1:0] or half addr[1] from rdata. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through. The result is registered to o_read_data_w.
- Reset (async, any state, including mid-access): FSM→IDLE; all MEM/WB outputs 0; o_misaligned_m=0. The bus request drops only if no mem_op is present.
- Outstanding rvalid arriving after a reset is ignored.

Test Plan:
- ALU op: alu=0x0000_1234, rd=5, regwrite=1, resultsrc=00 → next cycle o_alu_result_w=0x1234, o_rd_addr_w=5, o_regwrite_w=1, o_stall_m=0 throughout.
- SB: addr=0x0000_0006, wd=0xAABB_CCDD, gnt same cycle → req=1, we=1, be=0100, wdata=0xDDDD_DDDD, no stall.
- LB with wait: addr=0x003, rdata=0x80xx_xxxx, gnt after 2 cycles, rvalid 1 cycle later → o_stall_m high 4 cycles, o_read_data_w=0xFFFF_FF80, one bubble per stall cycle.
- LHU: addr=0x002, rdata=0x9ABC_1234 → o_read_data_w=0x0000_9ABC. LW: addr=0x004 → full word returned.
- Misaligned SW: addr=0x005 → no req, o_misaligned_m=1 for 1 cycle, o_regwrite_w=0.
- Reset asserted while in WAIT_RVALID → outputs 0 and FSM in IDLE immediately; a late rvalid after reset release causes no writeback.
